// File: rtl/delay_sched_pkg.sv
// Shared widths and FSM state encoding for the delay scheduler slice.
package delay_sched_pkg;

  localparam int DELAY_W = 5;
  localparam int CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // prio = 0 favours requester 0 when both ask at once
  logic prio;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      prio <= 1'b0;
    else if (|grant) prio <= grant[0];
  end

endmodule

// File: rtl/delay_sched.sv
// Schedules delay-line depth changes: drain old contents, apply the new depth, then settle.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter logic [DELAY_W-1:0] DEF_DELAY    = 5'd0,
  parameter int unsigned        SETTLE_EXTRA = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [DELAY_W-1:0] req0_delay,
  output logic               req0_ack,
  input  logic               req1_valid,
  input  logic [DELAY_W-1:0] req1_delay,
  output logic               req1_ack,
  output logic [DELAY_W-1:0] delay_num,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] EXTRA = CNT_W'(SETTLE_EXTRA);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc, settle_len;
  logic [DELAY_W-1:0] new_delay, new_delay_d, delay_num_d, sel_delay;
  logic               out_valid_d, done_d, arb_en;
  logic [1:0]         grant;

  // No grant during reset or in the done cycle, so a new change starts at least one cycle later
  assign arb_en = rst_n && (state == IDLE) && !done;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req0_ack   = grant[0];
  assign req1_ack   = grant[1];
  assign busy       = (state != IDLE);
  assign sel_delay  = grant[1] ? req1_delay : req0_delay;
  assign cnt_inc    = cnt + CNT_W'(1);
  assign settle_len = {1'b0, new_delay} + EXTRA;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    new_delay_d = new_delay;
    delay_num_d = delay_num;
    out_valid_d = out_valid;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          new_delay_d = sel_delay;
          if (sel_delay == delay_num) begin
            done_d = 1'b1;
          end else begin
            state_d     = DRAIN;
            cnt_d       = '0;
            out_valid_d = 1'b0;
          end
        end
      end
      // Hold for delay_num+1 cycles so every stage of the old line has flushed
      DRAIN: begin
        if (cnt == {1'b0, delay_num}) begin
          state_d = APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      APPLY: begin
        delay_num_d = new_delay;
        state_d     = SETTLE;
        cnt_d       = '0;
      end
      SETTLE: begin
        if (cnt_inc >= settle_len) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      new_delay <= '0;
      delay_num <= DEF_DELAY;
      out_valid <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      new_delay <= new_delay_d;
      delay_num <= delay_num_d;
      out_valid <= out_valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// Directed self-checking bench for delay_sched with default parameters (DEF_DELAY=0, SETTLE_EXTRA=2).
module tb_delay_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0] req0_delay = '0, req1_delay = '0;
  logic       req0_ack, req1_ack, out_valid, busy, done;
  logic [4:0] delay_num;

  int checks = 0;
  int errors = 0;
  int lowCnt, doneAt, chgAt, donePulses;

  always #5 clk = ~clk;

  delay_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_delay (req0_delay),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_delay (req1_delay),
    .req1_ack   (req1_ack),
    .delay_num  (delay_num),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] d0,
                               input logic v1, input logic [4:0] d1);
    req0_valid = v0;
    req0_delay = d0;
    req1_valid = v1;
    req1_delay = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Starts at the first cycle after an ack; returns cycles with out_valid low,
  // the cycle index of done (-1 if never) and of the first delay_num change.
  task automatic measureChange(input int budget, output int low, output int dAt, output int cAt);
    logic [4:0] startDn;
    startDn = delay_num;
    low = 0;
    dAt = -1;
    cAt = -1;
    for (int i = 0; i < budget; i++) begin
      if (!out_valid) low++;
      if (cAt < 0 && delay_num !== startDn) cAt = i;
      if (done) begin
        dAt = i;
        break;
      end
      tick();
    end
  endtask

  initial begin
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    doReset();
    checkOutput("rst_delay_num", delay_num, 5'd0);
    checkOutput("rst_out_valid", out_valid, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);

    // Scenario 1: 0 -> 4 via requester 0
    applyStimulus(1'b1, 5'd4, 1'b0, 5'd0);
    checkOutput("s1_ack0", req0_ack, 1'b1);
    checkOutput("s1_ack1", req1_ack, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    checkOutput("s1_busy", busy, 1'b1);
    measureChange(60, lowCnt, doneAt, chgAt);
    checkOutput("s1_done_at", doneAt, 8);
    checkOutput("s1_low_cycles", lowCnt, 8);
    checkOutput("s1_apply_at", chgAt, 2);
    checkOutput("s1_delay_num", delay_num, 5'd4);
    checkOutput("s1_out_valid", out_valid, 1'b1);
    tick();
    checkOutput("s1_done_pulse", done, 1'b0);

    // Scenario 2: round-robin with both requesters asking right after reset
    doReset();
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2);
    checkOutput("s2_first_ack0", req0_ack, 1'b1);
    checkOutput("s2_first_ack1", req1_ack, 1'b0);
    tick();
    checkOutput("s2_busy_no_ack", {req1_ack, req0_ack}, 2'b00);
    measureChange(60, lowCnt, doneAt, chgAt);
    checkOutput("s2_a_done_at", doneAt, 5);
    checkOutput("s2_done_blocks_ack", {req1_ack, req0_ack}, 2'b00);
    tick();
    checkOutput("s2_second_ack", {req1_ack, req0_ack}, 2'b10);
    tick();
    measureChange(60, lowCnt, doneAt, chgAt);
    checkOutput("s2_b_done_at", doneAt, 7);
    checkOutput("s2_b_delay_num", delay_num, 5'd2);
    tick();
    checkOutput("s2_third_ack", {req1_ack, req0_ack}, 2'b01);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    measureChange(60, lowCnt, doneAt, chgAt);
    checkOutput("s2_c_done_at", doneAt, 7);
    checkOutput("s2_c_delay_num", delay_num, 5'd1);

    // Reach depth 31 from a fresh reset using requester 1 alone
    doReset();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd31);
    checkOutput("s3_pre_ack1", req1_ack, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    measureChange(80, lowCnt, doneAt, chgAt);
    checkOutput("s3_pre_done_at", doneAt, 35);
    checkOutput("s3_pre_low", lowCnt, 35);
    checkOutput("s3_pre_delay_num", delay_num, 5'd31);
    tick();

    // Scenario 3: 31 -> 31 completes without disturbing out_valid
    applyStimulus(1'b1, 5'd31, 1'b0, 5'd0);
    checkOutput("s3_ack0", req0_ack, 1'b1);
    checkOutput("s3_ack_out_valid", out_valid, 1'b1);
    tick();
    checkOutput("s3_done", done, 1'b1);
    checkOutput("s3_out_valid", out_valid, 1'b1);
    checkOutput("s3_busy", busy, 1'b0);
    checkOutput("s3_done_blocks_ack", req0_ack, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checkOutput("s3_done_once", done, 1'b0);

    // Scenario 4: 31 -> 0, long drain must not wrap
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0);
    checkOutput("s4_ack0", req0_ack, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    measureChange(80, lowCnt, doneAt, chgAt);
    checkOutput("s4_apply_at", chgAt, 33);
    checkOutput("s4_done_at", doneAt, 35);
    checkOutput("s4_low", lowCnt, 35);
    checkOutput("s4_delay_num", delay_num, 5'd0);
    tick();

    // Scenario 5: reset in the middle of SETTLE for 0 -> 10
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd10);
    checkOutput("s5_ack1", req1_ack, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
    tick();
    checkOutput("s5_settle_delay", delay_num, 5'd10);
    checkOutput("s5_settle_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    checkOutput("s5_rst_delay_num", delay_num, 5'd0);
    checkOutput("s5_rst_out_valid", out_valid, 1'b1);
    checkOutput("s5_rst_busy", busy, 1'b0);
    checkOutput("s5_rst_done", done, 1'b0);
    rst_n = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) donePulses++;
      tick();
    end
    checkOutput("s5_no_done", donePulses, 0);
    checkOutput("s5_still_def", delay_num, 5'd0);

    // Scenario 6: requester 1 updates its depth while waiting; the value at ack wins
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    checkOutput("s6_ack0", req0_ack, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7);
    checkOutput("s6_wait_ack1_a", req1_ack, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd9);
    checkOutput("s6_wait_ack1_b", req1_ack, 1'b0);
    measureChange(60, lowCnt, doneAt, chgAt);
    checkOutput("s6_a_done_at", doneAt, 6);
    checkOutput("s6_a_delay_num", delay_num, 5'd3);
    checkOutput("s6_done_blocks_ack1", req1_ack, 1'b0);
    tick();
    checkOutput("s6_ack1", req1_ack, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0);
    measureChange(60, lowCnt, doneAt, chgAt);
    checkOutput("s6_b_done_at", doneAt, 16);
    checkOutput("s6_b_apply_at", chgAt, 5);
    checkOutput("s6_b_delay_num", delay_num, 5'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
